// File: rtl/loop_result_sink.sv
// rtl/loop_result_sink.sv - loop iteration counter and final-result FIFO
// Counts beats of each loop run and queues {result, iterations, saturated} on exit.
module loop_result_sink #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              UserCLK,
  input  logic              resetn,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [WIDTH-1:0]  in_br,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_sat,
  input  logic              out_ready,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [ITER_W-1:0] ITER_MAX = '1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               sat_q, sat_d;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [WIDTH-1:0]   data_mem_q [DEPTH];
  logic [ITER_W-1:0]  iter_mem_q [DEPTH];
  logic               sat_mem_q  [DEPTH];

  logic               accept, pop, push;
  logic [ITER_W-1:0]  push_iter, iter_inc;
  logic               push_sat, at_max;
  logic               unused_br;

  assign unused_br = ^in_br[WIDTH-1:1];

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q == RUN);

  assign out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign out_iter  = out_valid ? iter_mem_q[rd_ptr_q] : '0;
  assign out_sat   = out_valid ? sat_mem_q[rd_ptr_q]  : 1'b0;

  assign at_max   = (iter_q == ITER_MAX);
  assign iter_inc = at_max ? iter_q : iter_q + ITER_W'(1);

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    sat_d     = sat_q;
    push      = 1'b0;
    push_iter = '0;
    push_sat  = 1'b0;
    if (accept) begin
      if (state_q == IDLE) begin
        if (in_br[0]) begin
          state_d = RUN;
          iter_d  = ITER_W'(1);
        end else begin
          push      = 1'b1;
          push_iter = ITER_W'(1);
        end
      end else if (in_br[0]) begin
        iter_d = iter_inc;
        sat_d  = sat_q | at_max;
      end else begin
        // Exit beat reports its own saturation too, then the run state resets.
        push      = 1'b1;
        push_iter = iter_inc;
        push_sat  = sat_q | at_max;
        state_d   = IDLE;
        iter_d    = '0;
        sat_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      iter_q   <= '0;
      sat_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        iter_mem_q[i] <= '0;
        sat_mem_q[i]  <= 1'b0;
      end
    end else if (clear) begin
      state_q  <= IDLE;
      iter_q   <= '0;
      sat_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      sat_q   <= sat_d;
      if (push) begin
        data_mem_q[wr_ptr_q] <= in_data;
        iter_mem_q[wr_ptr_q] <= push_iter;
        sat_mem_q[wr_ptr_q]  <= push_sat;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
